// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter
//  Purpose  : Round-robin arbiter that shares one SPI master between
//             NUM_REQ requesters on a whole-transaction basis. The winner's
//             slave select and command word are captured at grant and held
//             for the whole frame. The received word and a one-cycle done
//             pulse go back to the winner, and a dead GAP cycle follows.
//
//  Ports    : clk, rst_n            clock, asynchronous active-low reset
//             req[N]                per-requester request (level)
//             req_ss[3N]            packed slave selects, [3i+2:3i]
//             req_data[16N]         packed command words, [16i+15:16i]
//             gnt[N]                one-hot grant for the whole transaction
//             done[N]               one-cycle completion pulse
//             rd_data[16]           received word, valid while done is high
//             wrt_SPI               one-cycle start pulse to the SPI master
//             SPI_data[16], ss[3]   command word / slave select to the master
//             SPI_done, SPI_rd_data frame-complete pulse / receive word
//             busy                  high from grant through the GAP cycle
//             timeout               sticky watchdog flag
//
//  Options  : `define SPI_ARB_TIMEOUT_EN adds a WAIT-state watchdog. It
//             completes a stuck frame after TIMEOUT_CYC cycles with
//             rd_data = 16'hFFFF and sets the sticky timeout flag. Without
//             the macro, timeout is tied low.
//
//  Revision : 1.0  initial release
// ============================================================================
module spi_bus_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [3*NUM_REQ-1:0]  req_ss,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [15:0]           rd_data,
  output logic                  wrt_SPI,
  output logic [15:0]           SPI_data,
  output logic [2:0]            ss,
  input  logic                  SPI_done,
  input  logic [15:0]           SPI_rd_data,
  output logic                  busy,
  output logic                  timeout
);

  localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] c_ss_none = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t             state_q,    state_d;
  logic [PTR_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q,      gnt_d;
  logic [NUM_REQ-1:0] done_q,     done_d;
  logic [15:0]        rd_data_q,  rd_data_d;
  logic               wrt_spi_q,  wrt_spi_d;
  logic [15:0]        spi_data_q, spi_data_d;
  logic [2:0]         ss_q,       ss_d;
  logic               busy_q,     busy_d;

  // Unpacked views of the packed per-requester buses
  logic [2:0]  ss_arr   [NUM_REQ];
  logic [15:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign ss_arr[gi]   = req_ss[3*gi +: 3];
    assign data_arr[gi] = req_data[16*gi +: 16];
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // At least 12 bits, wider if TIMEOUT_CYC needs more
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 12) ? $clog2(TIMEOUT_CYC + 1) : 12;
  // The counter reads k-1 during the k-th WAIT cycle, so firing at
  // TIMEOUT_CYC-1 completes the frame exactly TIMEOUT_CYC cycles into WAIT
  localparam logic [CNT_W-1:0] c_wd_limit = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // --------------------------------------------------------------------------
  // Round-robin search: first set req bit at or above rr_ptr, wrapping.
  // probe carries one spare bit so rr_ptr + k cannot overflow before the
  // modulo correction.
  // --------------------------------------------------------------------------
  logic             sel_valid;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W:0]   probe;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (probe >= (PTR_W+1)'(NUM_REQ)) begin
        probe = probe - (PTR_W+1)'(NUM_REQ);
      end
      if (!sel_valid && req[probe[PTR_W-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = probe[PTR_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rd_data_d  = rd_data_q;
    wrt_spi_d  = 1'b0;
    spi_data_d = spi_data_q;
    ss_d       = ss_q;
    busy_d     = busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
    wd_cnt_d   = wd_cnt_q;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          // The slave select and command word are captured here only.
          // Later changes on req_ss/req_data do not reach the frame.
          gnt_d      = NUM_REQ'(1) << sel_idx;
          ss_d       = ss_arr[sel_idx];
          spi_data_d = data_arr[sel_idx];
          busy_d     = 1'b1;
          rr_ptr_d   = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
          state_d    = LAUNCH;
        end
      end

      LAUNCH: begin
        // Registered, so the start pulse is seen in the first WAIT cycle
        wrt_spi_d = 1'b1;
        state_d   = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_cnt_d  = '0;
`endif
      end

      WAIT: begin
        if (SPI_done) begin
          rd_data_d = SPI_rd_data;
          done_d    = gnt_q;
          gnt_d     = '0;
          ss_d      = c_ss_none;
          state_d   = GAP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_cnt_q == c_wd_limit) begin
          rd_data_d = 16'hFFFF;
          done_d    = gnt_q;
          gnt_d     = '0;
          ss_d      = c_ss_none;
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          wd_cnt_d  = wd_cnt_q + 1'b1;
        end
`endif
      end

      GAP: begin
        // Dead cycle: lets the requester drop req after done before the
        // next arbitration samples it
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rd_data_q  <= 16'h0000;
      wrt_spi_q  <= 1'b0;
      spi_data_q <= 16'h0000;
      ss_q       <= c_ss_none;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      wrt_spi_q  <= wrt_spi_d;
      spi_data_q <= spi_data_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // Watchdog not built. TIMEOUT_CYC has no effect in this configuration.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign wrt_SPI  = wrt_spi_q;
  assign SPI_data = spi_data_q;
  assign ss       = ss_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_bus_arbiter
//  Purpose  : Randomized bench for spi_bus_arbiter. The requester driver
//             plans each round from the round-robin rule and queues the
//             expected transactions. A behavioural SPI slave answers each
//             frame. An independent monitor compares every launch and
//             completion against the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int MAX_DLY    = 12;
  localparam int SINGLE_DLY = 10;
`else
  localparam int MAX_DLY    = 20;
  localparam int SINGLE_DLY = 20;
`endif

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [3*N-1:0]  req_ss;
  logic [16*N-1:0] req_data;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic [15:0]   rd_data;
  logic          wrt_SPI;
  logic [15:0]   SPI_data;
  logic [2:0]    ss;
  logic          SPI_done;
  logic [15:0]   SPI_rd_data;
  logic          busy;
  logic          timeout;

  spi_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ss(req_ss), .req_data(req_data),
    .gnt(gnt), .done(done), .rd_data(rd_data), .wrt_SPI(wrt_SPI),
    .SPI_data(SPI_data), .ss(ss), .SPI_done(SPI_done),
    .SPI_rd_data(SPI_rd_data), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          idx;
    logic [2:0]  ss;
    logic [15:0] data;
    logic [15:0] rd;
    int          lat;   // expected cycle of wrt_SPI, -1 = not checked
    int          dly;   // expected wrt_SPI-to-done cycles, -1 = not checked
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] resp_q[$];
  int          drv_order[$];

  int model_rr     = 0;
  bit slave_mute   = 1'b0;
  int fixed_delay  = -1;
  bit force_mutate = 1'b0;
  bit force_drop   = 1'b0;

  // ---------------- behavioural SPI slave ----------------
  initial begin
    bit          armed = 1'b0;
    int          cnt   = 0;
    logic [15:0] cur   = 16'h0;
    SPI_done    = 1'b0;
    SPI_rd_data = 16'h0;
    forever begin
      @(negedge clk);
      SPI_done    = 1'b0;
      SPI_rd_data = 16'($urandom);
      if (!rst_n) begin
        armed = 1'b0;
      end else begin
        if (wrt_SPI) begin
          cur   = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0;
          cnt   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(MAX_DLY, 0));
          armed = !slave_mute;
        end
        if (armed) begin
          if (cnt == 0) begin
            SPI_done    = 1'b1;
            SPI_rd_data = cur;
            armed       = 1'b0;
          end else begin
            cnt--;
          end
        end else if (!slave_mute && done != '0 && $urandom_range(1, 0) == 1) begin
          SPI_done = 1'b1;   // stray pulse during GAP, must be ignored
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit   active   = 1'b0;
    bit   bad      = 1'b0;
    bit   prev_wrt = 1'b0;
    bit   prev_done = 1'b0;
    int   wrt_cyc  = 0;
    txn_t cur;
    cur = '{idx: 0, ss: 3'b0, data: 16'h0, rd: 16'h0, lat: -1, dly: -1};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; prev_wrt = 1'b0; prev_done = 1'b0;
      end else begin
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("done_onehot0", 32'($onehot0(done)), 32'd1);
        if (prev_wrt)  chk("wrt_single_cycle", 32'(wrt_SPI), 32'd0);
        if (prev_done) begin
          chk("done_single_cycle", 32'(done), 32'd0);
          chk("busy_low_after_gap", 32'(busy), 32'd0);
        end
        prev_wrt  = wrt_SPI;
        prev_done = (done != '0);
        if (wrt_SPI) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_wrt", 32'(wrt_SPI), 32'd0);
          end else begin
            cur = exp_q[0];
            chk("gnt_at_launch", 32'(gnt), 32'd1 << cur.idx);
            chk("ss_at_launch", 32'(ss), 32'(cur.ss));
            chk("data_at_launch", 32'(SPI_data), 32'(cur.data));
            chk("busy_at_launch", 32'(busy), 32'd1);
            if (cur.lat >= 0) chk("req_to_wrt_latency", 32'(cyc), 32'(cur.lat));
            active = 1'b1; bad = 1'b0; wrt_cyc = cyc;
          end
        end else if (active && done == '0) begin
          if (32'(gnt) !== (32'd1 << cur.idx) || ss !== cur.ss || SPI_data !== cur.data) bad = 1'b1;
        end
        if (done != '0) begin
          if (!active) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            chk("done_target", 32'(done), 32'd1 << cur.idx);
            chk("rd_data", 32'(rd_data), 32'(cur.rd));
            chk("data_held_to_done", 32'(SPI_data), 32'(cur.data));
            chk("gnt_cleared_at_done", 32'(gnt), 32'd0);
            chk("ss_released_at_done", 32'(ss), 32'd7);
            chk("busy_in_gap", 32'(busy), 32'd1);
            chk("stable_during_wait", 32'(bad), 32'd0);
            if (cur.dly >= 0) chk("wrt_to_done_cycles", 32'(cyc - wrt_cyc), 32'(cur.dly));
            void'(exp_q.pop_front());
            active = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Plan a round: every requester in mask is served once, in round-robin
  // order starting at the model pointer.
  task automatic issue_round(input logic [N-1:0] mask, input bit rnd,
                             input bit fix_rd, input logic [15:0] rd_val, input int dly);
    int   start = model_rr;
    int   idx;
    int   last  = -1;
    bit   first = 1'b1;
    txn_t t;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && rnd) begin
        req_ss[3*i +: 3]    = 3'($urandom_range(6, 0));
        req_data[16*i +: 16] = 16'($urandom);
      end
    end
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (mask[idx]) begin
        t.idx  = idx;
        t.ss   = req_ss[3*idx +: 3];
        t.data = req_data[16*idx +: 16];
        t.rd   = fix_rd ? rd_val : 16'($urandom);
        t.lat  = first ? cyc + 2 : -1;
        t.dly  = dly;
        first  = 1'b0;
        exp_q.push_back(t);
        resp_q.push_back(t.rd);
        drv_order.push_back(idx);
        last = idx;
      end
    end
    if (last >= 0) model_rr = (last + 1) % N;
    req = req | mask;
  endtask

  task automatic recover();
    rst_n = 1'b0;
    exp_q.delete(); resp_q.delete(); drv_order.delete();
    req = '0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    model_rr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_round();
    int budget = 300;
    int owner;
    while (drv_order.size() > 0) begin
      @(negedge clk);
      budget--;
      if (wrt_SPI && drv_order.size() > 0) begin
        owner = drv_order[0];
        if (force_mutate || $urandom_range(1, 0) == 1) begin
          req_data[16*owner +: 16] = force_mutate ? 16'hBEEF : 16'($urandom);
          req_ss[3*owner +: 3]     = 3'($urandom);
        end
        if (force_drop || $urandom_range(3, 0) == 0) req[owner] = 1'b0;
      end
      if (done != '0 && drv_order.size() > 0) begin
        req[drv_order[0]] = 1'b0;
        void'(drv_order.pop_front());
      end
      if (budget <= 0) begin
        chk("round_within_budget", 32'(drv_order.size()), 32'd0);
        recover();
      end
    end
    repeat (2 + $urandom_range(3, 0)) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int b;
    rst_n = 1'b0; req = '0; req_ss = '0; req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wrt", 32'(wrt_SPI), 32'd0);
    chk("rst_spi_data", 32'(SPI_data), 32'd0);
    chk("rst_ss", 32'(ss), 32'd7);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request with a fixed-latency slave
    req_ss[2:0] = 3'b000; req_data[15:0] = 16'h1328; fixed_delay = SINGLE_DLY;
    issue_round(3'b001, 1'b0, 1'b1, 16'h00A5, SINGLE_DLY + 1);
    run_round();
    fixed_delay = -1;
    chk("ss_idle_after_single", 32'(ss), 32'd7);

    // Bring the pointer back to 0, then full contention: 0,1,2 then 0
    issue_round(3'b100, 1'b1, 1'b0, 16'h0, -1); run_round();
    issue_round(3'b111, 1'b1, 1'b0, 16'h0, -1); run_round();
    issue_round(3'b001, 1'b1, 1'b0, 16'h0, -1); run_round();

    // Stability: requester 1 data changes to BEEF during WAIT
    req_data[31:16] = 16'h1305; req_ss[5:3] = 3'b010; force_mutate = 1'b1;
    issue_round(3'b010, 1'b0, 1'b0, 16'h0, -1); run_round();
    force_mutate = 1'b0;

    // Early release by requester 2
    force_drop = 1'b1;
    issue_round(3'b100, 1'b1, 1'b0, 16'h0, -1); run_round();
    force_drop = 1'b0;

    // Random rounds
    for (int r = 0; r < 40; r++) begin
      issue_round(3'($urandom_range(7, 1)), 1'b1, 1'b0, 16'h0, -1);
      run_round();
    end

    // Reset in the middle of WAIT
    req_ss[5:3] = 3'b100; req_data[31:16] = 16'($urandom); slave_mute = 1'b1;
    issue_round(3'b010, 1'b0, 1'b0, 16'h0, -1);
    b = 0;
    @(negedge clk);
    while (!wrt_SPI && b < 10) begin @(negedge clk); b++; end
    chk("reset_test_launch_seen", 32'(wrt_SPI), 32'd1);
    req_ss[8:6] = 3'($urandom_range(6, 0)); req_data[47:32] = 16'($urandom); req[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("ss_before_reset", 32'(ss), 32'd4);
    rst_n = 1'b0;
    exp_q.delete(); resp_q.delete(); drv_order.delete();
    #1;
    chk("rst_async_ss", 32'(ss), 32'd7);
    chk("rst_async_gnt", 32'(gnt), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    repeat (2) begin @(negedge clk); chk("no_done_in_reset", 32'(done), 32'd0); end
    rst_n = 1'b1; slave_mute = 1'b0; model_rr = 0;
    issue_round(3'b110, 1'b0, 1'b0, 16'h0, -1);
    run_round();

`ifdef SPI_ARB_TIMEOUT_EN
    chk("timeout_clear_before", 32'(timeout), 32'd0);
    slave_mute = 1'b1;
    issue_round(3'b001, 1'b1, 1'b1, 16'hFFFF, TO);
    run_round();
    slave_mute = 1'b0;
    chk("timeout_set", 32'(timeout), 32'd1);
    issue_round(3'b010, 1'b1, 1'b0, 16'h0, -1);
    run_round();
    chk("timeout_sticky", 32'(timeout), 32'd1);
`else
    chk("timeout_tied_low", 32'(timeout), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single SPI master (AFE gain DACs, trigger DAC, calibration EEPROM) between NUM_REQ requesters, e.g. the command processor, the calibration-coefficient loader and the trigger-level updater.
- Round-robin arbitration on a whole-transaction basis. Holds slave-select and data stable for the full SPI frame, then returns read data and a done pulse to the granted requester.
- Sits between the requesters and the SPI master; owns wrt_SPI, SPI_data and ss.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYC, 4095, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester transaction request, level
- req_ss  input  3*NUM_REQ  packed slave select; requester i uses [3i+2:3i]
- req_data  input  16*NUM_REQ  packed SPI command word; requester i uses [16i+15:16i]
- gnt  output  NUM_REQ  one-hot grant, high for the whole transaction
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester
- rd_data  output  16  word shifted in from the slave, valid while done is high
- wrt_SPI  output  1  one-cycle start pulse to the SPI master
- SPI_data  output  16  command word to the SPI master
- ss  output  3  slave select to the SPI master; 3'b111 means none
- SPI_done  input  1  SPI master frame-complete pulse
- SPI_rd_data  input  16  SPI master receive word
- busy  output  1  high from grant through the GAP cycle
- timeout  output  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset values: gnt=0, done=0, rd_data=16'h0000, wrt_SPI=0, SPI_data=16'h0000, ss=3'b111, busy=0, timeout=0, rr_ptr=0, state=IDLE. All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, GAP.
- IDLE: when any req bit is set, select the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - Register gnt, ss=req_ss[i] and SPI_data=req_data[i]; set busy.
  - Next state is LAUNCH.
  - rr_ptr becomes (i+1) mod NUM_REQ.
- LAUNCH: wrt_SPI=1 for exactly this cycle. Next state is WAIT.
  - Request-to-wrt_SPI latency is 2 cycles: req sampled at edge N, wrt_SPI high after edge N+1.
- WAIT: ss, SPI_data and gnt are held stable. On SPI_done:
  - rd_data <= SPI_rd_data, done[i] <= 1 for one cycle, gnt <= 0, ss <= 3'b111.
  - Next state is GAP.
- GAP: one dead cycle, with busy still 1, so the requester can drop req after done. Next state is IDLE.
- req_ss and req_data are sampled only at grant; later changes are ignored for the current transaction.
- A requester dropping req while granted does not abort the transaction; the frame completes and done is still pulsed.
- Simultaneous requests: rr_ptr priority.
  - With all requesting and rr_ptr=0, the order is 0,1,2,0,...
  - A requester that keeps req high is re-granted only after the others get a turn.
- SPI_done outside WAIT is ignored.
- Reset mid-transaction: everything returns to reset values immediately. ss goes to 3'b111 asynchronously; no done pulse is issued.
- At most one gnt bit is ever set, and at most one done bit is ever set.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With it defined:
  - A 12-bit-plus counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without SPI_done: set timeout (sticky until reset), pulse done[i] with rd_data=16'hFFFF, set ss=3'b111, and go to GAP.
- Without it: WAIT waits indefinitely; the timeout output is tied to 0 and the counter logic is absent.

Test Plan:
- Single request: req=3'b001, req_ss[2:0]=3'b000, req_data[15:0]=16'h1328; SPI_done 20 cycles after wrt_SPI with SPI_rd_data=16'h00A5 -> gnt=3'b001, one wrt_SPI pulse with SPI_data=16'h1328 and ss=3'b000, then done=3'b001 for 1 cycle with rd_data=16'h00A5, then ss=3'b111.
- Contention: req=3'b111 held, rr_ptr=0 -> grants in order 001,010,100,001. Exactly one wrt_SPI per transaction; a GAP cycle follows each done.
- Stability: change req_data[31:16] from 16'h1305 to 16'hBEEF during WAIT of requester 1 -> SPI_data stays 16'h1305 until done.
- Early release: requester 2 drops req one cycle after wrt_SPI -> transaction completes and done[2] still pulses.
- Reset mid-WAIT: assert rst_n=0 with ss=3'b100 -> ss=3'b111, gnt=0, no done pulse. After release, a pending req=3'b010 is granted first with rr_ptr=0 search.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no SPI_done -> done pulses 16 cycles after entering WAIT with rd_data=16'hFFFF; timeout=1 and stays 1.
